ram_rd_chk: RTL and testbench
=============================

# ram_rd_chk

Read-back checker for the dual-port RAM test. Sits on the read port, directly downstream of the RAM write stage. Waits for the write burst to finish, then sweeps every RAM address once, and compares each returned word against the value the write stage stored (data equals address). Reports pass/fail, error count and first failing address, for LEDs and SignalTap.

## Interface
- ADDR_W, 5, RAM address width
- DATA_W, 8, RAM data width; must be ≥ ADDR_W
- DEPTH, 32, words swept, addresses 0..DEPTH-1; DEPTH ≤ 2^ADDR_W
- RD_LAT, 2, cycles from address issue to valid ram_rd_data; legal 1..4
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- ram_wr_en  input  1  write enable from the write stage; its falling edge starts the read sweep
- ram_rd_data  input  DATA_W  RAM read-port output
- ram_rd_en  output  1  read enable to the RAM, registered
- ram_rd_addr  output  ADDR_W  read address to the RAM, registered
- rd_done  output  1  sweep and all compares complete; sticky until reset
- err_flag  output  1  sticky; set on the first mismatch
- err_cnt  output  ADDR_W+1  number of mismatches, saturating
- first_err_addr  output  ADDR_W  address of the first mismatch

## Operation
- Edge detect: `wr_en_d` is a register of ram_wr_en, reset to 0. `start = wr_en_d & ~ram_wr_en`.
- FSM states: IDLE, READ, DRAIN, DONE. Reset state is IDLE.
  - IDLE → READ on `start`.
  - READ: ram_rd_en=1; ram_rd_addr steps 0..DEPTH-1, one per cycle. Leave for DRAIN after address DEPTH-1 is issued.
  - DRAIN: ram_rd_en=0. Stay RD_LAT cycles, then go to DONE.
  - DONE: terminal until reset. Further ram_wr_en edges are ignored.
- `start` is ignored outside IDLE.
- Compare pipeline: an RD_LAT-deep shift register carries (valid, address) for each issued read.
  - At the pipeline tail with valid=1, compare ram_rd_data against the address zero-extended to DATA_W.
  - On a mismatch: err_flag←1 and err_cnt increments. err_cnt holds at 2^(ADDR_W+1)−1.
  - On the first mismatch only, first_err_addr takes the tail address.
- Outside READ, ram_rd_addr is 0 and ram_rd_en is 0.

## Timing
- Reset values: ram_rd_en=0, ram_rd_addr=0, rd_done=0, err_flag=0, err_cnt=0, first_err_addr=0. Pipeline valid bits are cleared.
- Edge T: the first edge at which wr_en_d=1 and ram_wr_en=0 are sampled. After T: ram_rd_en=1 and ram_rd_addr=0.
- Read for address k is issued in cycle T+1+k, for k=0..DEPTH-1.
- Data for address k is sampled at the end of cycle T+1+k+RD_LAT. Error outputs update on that edge.
- rd_done rises in cycle T+1+DEPTH+RD_LAT. err_* values are final by then.
- Reset mid-sweep, asynchronous: all state is cleared and the FSM returns to IDLE. A new sweep needs a fresh falling edge.
- Reset release with ram_wr_en already 1: no start, because wr_en_d is 0.
- ram_wr_en pulsing during READ or DRAIN: no effect on the sweep.

## Configuration
- RAM_RD_CHK_EN
  - Defined: compare pipeline and error logic are built as described.
  - Undefined: the sweep and rd_done are unchanged. err_flag, err_cnt and first_err_addr are tied to 0, and no compare logic is synthesized.

## Test plan
- Defaults, bench model RAM preloaded by the write stage (word k = k), ram_wr_en high 32 cycles then low.
  - ram_rd_en is high exactly 32 cycles with addresses 0..31.
  - rd_done rises 35 cycles after T.
  - err_flag=0, err_cnt=0.
- Same stimulus, RAM word 5 corrupted to 0xA5 → err_flag=1, err_cnt=1, first_err_addr=5.
- Words 3, 17 and 31 corrupted → err_cnt=3, first_err_addr=3. The last mismatch is counted before rd_done rises.
- rst_n low for 2 cycles while ram_rd_addr=10 → all outputs return to reset values immediately. No reads follow until the next ram_wr_en falling edge; then a full sweep from address 0.
- RD_LAT=1 and RD_LAT=4 builds → rd_done at T+1+32+RD_LAT, err_cnt=0 with a correct model of matching latency.
- RAM_RD_CHK_EN undefined, word 5 corrupted → identical sweep and rd_done timing, err_flag=0, err_cnt=0.

Source files
------------

// File: rtl/ram_rd_chk.sv
// Read-back checker for the dual-port RAM test: sweeps every address once after the write burst
// and compares each word against its own address. Error logic is built only when RAM_RD_CHK_EN is defined.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the falling edge of ram_wr_en
// READ  | issuing reads, one address per cycle, 0..DEPTH-1
// DRAIN | no new reads; waiting RD_LAT cycles for the last data
// DONE  | sweep complete, terminal until reset
module ram_rd_chk #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              rd_done,
  output logic              err_flag,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, next_state;
  logic              wr_en_d;
  logic              start;
  logic [2:0]        drain_cnt;
  logic              rd_en_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_en_d <= 1'b0;
    else        wr_en_d <= ram_wr_en;
  end

  assign start = wr_en_d & ~ram_wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = READ;
      READ:    if (ram_rd_addr == ADDR_W'(DEPTH - 1)) next_state = DRAIN;
      DRAIN:   if (drain_cnt == 3'd0) next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Read controls are computed from next_state so they can be registered at the FSM edge.
  always_comb begin
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = '0;
    rd_done     = (state == DONE);
    if (next_state == READ) begin
      rd_en_nxt   = 1'b1;
      rd_addr_nxt = (state == READ) ? ram_rd_addr + ADDR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_rd_en   <= rd_en_nxt;
      ram_rd_addr <= rd_addr_nxt;
    end
  end

  // Drain timer: loaded while not draining, counts down to terminal count zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 drain_cnt <= 3'(RD_LAT - 1);
    else if (state != DRAIN)    drain_cnt <= 3'(RD_LAT - 1);
    else if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
  end

`ifdef RAM_RD_CHK_EN
  logic [RD_LAT-1:0] pipe_vld;
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic              tail_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= ram_rd_en;
      pipe_addr[0] <= ram_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign tail_mis = pipe_vld[RD_LAT-1] &&
                    (ram_rd_data != DATA_W'(pipe_addr[RD_LAT-1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (tail_mis) begin
      err_flag <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + (ADDR_W+1)'(1);
      if (!err_flag)     first_err_addr <= pipe_addr[RD_LAT-1];
    end
  end
`else
  logic unused_rd_data;

  assign unused_rd_data = ^ram_rd_data;
  assign err_flag       = 1'b0;
  assign err_cnt        = '0;
  assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_rd_chk.sv
// Bench for ram_rd_chk: model RAM at read latencies 1, 2 and 4, read-address scoreboard on the RD_LAT=2
// instance, and end-of-sweep checks of rd_done timing and error reporting.
module tb_ram_rd_chk;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;
`ifdef RAM_RD_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_wr_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_edge = 0;
  logic [DW-1:0] mem [DEPTH];
  rd_exp_t exp_q [$];

  logic          en_l1, en_l2, en_l4, done_l1, done_l2, done_l4;
  logic          errf_l1, errf_l2, errf_l4;
  logic [AW-1:0] addr_l1, addr_l2, addr_l4, first_l1, first_l2, first_l4;
  logic [AW:0]   errc_l1, errc_l2, errc_l4;
  logic [DW-1:0] data_l1, data_l2, data_l4;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2 [2];
  logic [DW-1:0] d4 [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_rd_chk #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ram_wr_en(ram_wr_en), .ram_rd_data(data_l1),
    .ram_rd_en(en_l1), .ram_rd_addr(addr_l1), .rd_done(done_l1),
    .err_flag(errf_l1), .err_cnt(errc_l1), .first_err_addr(first_l1));

  ram_rd_chk #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .ram_wr_en(ram_wr_en), .ram_rd_data(data_l2),
    .ram_rd_en(en_l2), .ram_rd_addr(addr_l2), .rd_done(done_l2),
    .err_flag(errf_l2), .err_cnt(errc_l2), .first_err_addr(first_l2));

  ram_rd_chk #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .ram_wr_en(ram_wr_en), .ram_rd_data(data_l4),
    .ram_rd_en(en_l4), .ram_rd_addr(addr_l4), .rd_done(done_l4),
    .err_flag(errf_l4), .err_cnt(errc_l4), .first_err_addr(first_l4));

  // Model RAM read port: address registered, then RD_LAT-1 more output stages.
  always @(posedge clk) begin
    d1    <= mem[addr_l1];
    d2[0] <= mem[addr_l2];
    d2[1] <= d2[0];
    d4[0] <= mem[addr_l4];
    for (int i = 1; i < 4; i++) d4[i] <= d4[i-1];
  end
  assign data_l1 = d1;
  assign data_l2 = d2[1];
  assign data_l4 = d4[3];

  // Read scoreboard: each issued read must match the next expected (address, cycle).
  always @(negedge clk) begin
    rd_exp_t e;
    if (rst_n && en_l2) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: read of addr %0d at cycle %0d, required no read", addr_l2, cyc);
      end else begin
        e = exp_q.pop_front();
        if (addr_l2 !== e.addr || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rd_issue: addr %0d at cycle %0d, required addr %0d at cycle %0d",
                   addr_l2, cyc, e.addr, e.cyc);
        end
      end
    end
  end

  function automatic int first_set(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    ram_wr_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [31:0] bad_mask);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = bad_mask[i] ? 8'hA5 : DW'(i);
      ram_wr_en = 1'b1;
      @(posedge clk);
      #1;
    end
    ram_wr_en = 1'b0;
    t_edge = cyc + 1;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back('{addr: AW'(k), cyc: t_edge + k});
  endtask

  task automatic wait_done(output int c1, output int c2, output int c4, output logic [AW:0] cnt_at_done);
    c1 = -1; c2 = -1; c4 = -1; cnt_at_done = '1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_l1 && c1 < 0) c1 = cyc;
      if (done_l2 && c2 < 0) begin c2 = cyc; cnt_at_done = errc_l2; end
      if (done_l4 && c4 < 0) c4 = cyc;
      if (c1 >= 0 && c2 >= 0 && c4 >= 0) break;
    end
  endtask

  task automatic test_reset();
    int n_rd;
    rst_n = 1'b0;
    ram_wr_en = 1'b1;
    #3;
    n_checks++; if (en_l2 !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %0b, required 0", en_l2); end
    n_checks++; if (addr_l2 !== '0) begin n_fail++; $display("FAIL rst_rd_addr: got %0d, required 0", addr_l2); end
    n_checks++; if (done_l2 !== 1'b0) begin n_fail++; $display("FAIL rst_rd_done: got %0b, required 0", done_l2); end
    n_checks++; if (errf_l2 !== 1'b0) begin n_fail++; $display("FAIL rst_err_flag: got %0b, required 0", errf_l2); end
    n_checks++; if (errc_l2 !== '0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d, required 0", errc_l2); end
    n_checks++; if (first_l2 !== '0) begin n_fail++; $display("FAIL rst_first_err: got %0d, required 0", first_l2); end
    // Release with ram_wr_en high, drop it before any edge samples it: no sweep may start.
    @(negedge clk);
    rst_n = 1'b1;
    #1 ram_wr_en = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (en_l2) n_rd++; end
    n_checks++; if (n_rd != 0) begin n_fail++; $display("FAIL rst_release_start: got %0d reads, required 0", n_rd); end
    n_checks++; if (done_l2 !== 1'b0) begin n_fail++; $display("FAIL rst_release_done: got %0b, required 0", done_l2); end
  endtask

  task automatic test_clean_sweep();
    int c1, c2, c4;
    logic [AW:0] cad;
    apply_reset();
    write_burst(32'h0);
    wait_done(c1, c2, c4, cad);
    n_checks++; if (c2 != t_edge + 34) begin n_fail++; $display("FAIL clean_done_l2: cycle %0d, required %0d", c2, t_edge + 34); end
    n_checks++; if (c1 != t_edge + 33) begin n_fail++; $display("FAIL clean_done_l1: cycle %0d, required %0d", c1, t_edge + 33); end
    n_checks++; if (c4 != t_edge + 36) begin n_fail++; $display("FAIL clean_done_l4: cycle %0d, required %0d", c4, t_edge + 36); end
    n_checks++; if (errf_l2 !== 1'b0) begin n_fail++; $display("FAIL clean_err_flag: got %0b, required 0", errf_l2); end
    n_checks++; if (errc_l2 !== '0) begin n_fail++; $display("FAIL clean_err_cnt_l2: got %0d, required 0", errc_l2); end
    n_checks++; if (errc_l1 !== '0) begin n_fail++; $display("FAIL clean_err_cnt_l1: got %0d, required 0", errc_l1); end
    n_checks++; if (errc_l4 !== '0) begin n_fail++; $display("FAIL clean_err_cnt_l4: got %0d, required 0", errc_l4); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clean_rd_count: %0d reads missing, required 0", exp_q.size()); end
  endtask

  task automatic test_corrupt(input string name, input logic [31:0] mask);
    int c1, c2, c4;
    logic [AW:0] cad;
    int exp_cnt, exp_first;
    exp_cnt   = CHK_EN ? $countones(mask) : 0;
    exp_first = CHK_EN ? first_set(mask) : 0;
    apply_reset();
    write_burst(mask);
    wait_done(c1, c2, c4, cad);
    n_checks++; if (c2 != t_edge + 34) begin n_fail++; $display("FAIL %s_done: cycle %0d, required %0d", name, c2, t_edge + 34); end
    n_checks++; if (errf_l2 !== CHK_EN) begin n_fail++; $display("FAIL %s_err_flag: got %0b, required %0b", name, errf_l2, CHK_EN); end
    n_checks++; if (cad !== (AW+1)'(exp_cnt)) begin n_fail++; $display("FAIL %s_cnt_at_done: got %0d, required %0d", name, cad, exp_cnt); end
    n_checks++; if (first_l2 !== AW'(exp_first)) begin n_fail++; $display("FAIL %s_first_err: got %0d, required %0d", name, first_l2, exp_first); end
    n_checks++; if (errc_l1 !== (AW+1)'(exp_cnt) || errf_l1 !== CHK_EN || first_l1 !== AW'(exp_first))
      begin n_fail++; $display("FAIL %s_l1: cnt %0d flag %0b first %0d, required %0d %0b %0d", name, errc_l1, errf_l1, first_l1, exp_cnt, CHK_EN, exp_first); end
    n_checks++; if (errc_l4 !== (AW+1)'(exp_cnt) || errf_l4 !== CHK_EN || first_l4 !== AW'(exp_first))
      begin n_fail++; $display("FAIL %s_l4: cnt %0d flag %0b first %0d, required %0d %0b %0d", name, errc_l4, errf_l4, first_l4, exp_cnt, CHK_EN, exp_first); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_rd_count: %0d reads missing, required 0", name, exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    int c1, c2, c4, n_rd;
    logic [AW:0] cad;
    bit found;
    apply_reset();
    write_burst(32'h0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en_l2 && addr_l2 == AW'(10)) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_reach_addr10: got not reached, required reached"); end
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++; if (en_l2 !== 1'b0 || addr_l2 !== '0) begin n_fail++; $display("FAIL mid_rst_rd: en %0b addr %0d, required 0 0", en_l2, addr_l2); end
    n_checks++; if (done_l2 !== 1'b0 || errf_l2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: done %0b err %0b, required 0 0", done_l2, errf_l2); end
    n_checks++; if (errc_l2 !== '0 || first_l2 !== '0) begin n_fail++; $display("FAIL mid_rst_err: cnt %0d first %0d, required 0 0", errc_l2, first_l2); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (en_l2) n_rd++; end
    n_checks++; if (n_rd != 0) begin n_fail++; $display("FAIL mid_no_restart: got %0d reads, required 0", n_rd); end
    @(posedge clk); #1;
    write_burst(32'h0);
    wait_done(c1, c2, c4, cad);
    n_checks++; if (c2 != t_edge + 34) begin n_fail++; $display("FAIL mid_resweep_done: cycle %0d, required %0d", c2, t_edge + 34); end
    n_checks++; if (cad !== '0) begin n_fail++; $display("FAIL mid_resweep_cnt: got %0d, required 0", cad); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_rd_count: %0d reads missing, required 0", exp_q.size()); end
  endtask

  task automatic test_wr_glitch();
    int c1, c2, c4, n_rd;
    logic [AW:0] cad;
    apply_reset();
    write_burst(32'h0);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    ram_wr_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    ram_wr_en = 1'b0;
    for (int i = 0; i < 100 && cyc < t_edge + 31; i++) begin @(posedge clk); #1; end
    ram_wr_en = 1'b1;
    @(posedge clk); #1;
    ram_wr_en = 1'b0;
    wait_done(c1, c2, c4, cad);
    n_checks++; if (c2 != t_edge + 34) begin n_fail++; $display("FAIL glitch_done: cycle %0d, required %0d", c2, t_edge + 34); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_rd_count: %0d reads missing, required 0", exp_q.size()); end
    @(posedge clk); #1;
    ram_wr_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    ram_wr_en = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (en_l2) n_rd++; end
    n_checks++; if (n_rd != 0) begin n_fail++; $display("FAIL done_ignores_wr: got %0d reads, required 0", n_rd); end
    n_checks++; if (done_l2 !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %0b, required 1", done_l2); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_clean_sweep();
    test_corrupt("word5", 32'h0000_0020);
    test_corrupt("words_3_17_31", 32'h8002_0008);
    test_mid_reset();
    test_wr_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
